speed_select_ctrl: RTL and testbench

SPEED_SELECT_CTRL -- requirements
Module: speed_select_ctrl

---
 rtl/speed_pkg.sv | 11 +
 rtl/key_debounce.sv | 73 +++++++
 rtl/speed_select_ctrl.sv | 71 +++++++
 tb/tb_speed_select_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared speed code definitions for the speed selector and the speed controller.
package speed_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_50MHZ      = 2'b00;
  localparam speed_t SPEED_1HZ        = 2'b01;
  localparam speed_t SPEED_HALF_HZ    = 2'b10;
  localparam speed_t SPEED_QUARTER_HZ = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, debounce filter and
// auto-repeat, producing the clean (active-low) level and a press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level_n,
  output logic press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;

  logic [1:0]    sync;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rep_cnt;
  logic          differ;
  logic          settle;
  logic          repeat_hit;

  assign differ     = (sync[1] != level_n);
  assign settle     = differ && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign repeat_hit = !level_n && (rep_cnt == RW'(REPEAT_CYCLES - 1));

  // Synchronise the asynchronous pin; idles at released.
  always_ff @(posedge clock) begin
    if (reset) sync <= '1;
    else       sync <= {sync[0], key_n};
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_n <= 1'b1;
      deb_cnt <= '0;
    end else if (settle) begin
      level_n <= ~level_n;
      deb_cnt <= '0;
    end else if (differ) begin
      deb_cnt <= deb_cnt + DW'(1);
    end else begin
      deb_cnt <= '0;
    end
  end

  // Press pulse on accepted press, plus one every REPEAT_CYCLES while held.
  // A release being accepted this cycle takes priority over a repeat step.
  always_ff @(posedge clock) begin
    if (reset) begin
      press   <= 1'b0;
      rep_cnt <= '0;
    end else begin
      press <= 1'b0;
      if (settle) begin
        press   <= level_n;
        rep_cnt <= '0;
      end else if (!level_n) begin
        if (repeat_hit) begin
          press   <= 1'b1;
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end else begin
        rep_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/speed_select_ctrl.sv
// Speed code selector: two debounced pushbuttons step a 2-bit speed code
// up or down, with optional wrap-around, and flag each actual change.
module speed_select_ctrl
  import speed_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter bit          WRAP            = 1'b1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   key_up_n,
  input  logic   key_down_n,
  output speed_t speed_sel,
  output logic   changed
);

  logic   up_press;
  logic   down_press;
  logic   up_level_n;
  logic   down_level_n;
  speed_t next_sel;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) up_key (
    .clock  (clock),
    .reset  (reset),
    .key_n  (key_up_n),
    .level_n(up_level_n),
    .press  (up_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) down_key (
    .clock  (clock),
    .reset  (reset),
    .key_n  (key_down_n),
    .level_n(down_level_n),
    .press  (down_press)
  );

  // Clean levels are not needed for arbitration here.
  logic unused_levels;
  assign unused_levels = up_level_n ^ down_level_n;

  // Arbitrate events: simultaneous up/down cancel; ends wrap or saturate.
  always_comb begin
    next_sel = speed_sel;
    if (up_press && !down_press) begin
      if (!(speed_sel == SPEED_QUARTER_HZ && !WRAP)) next_sel = speed_sel + 2'd1;
    end else if (down_press && !up_press) begin
      if (!(speed_sel == SPEED_50MHZ && !WRAP)) next_sel = speed_sel - 2'd1;
    end
  end

  // Register the speed code and pulse changed only on an actual change.
  always_ff @(posedge clock) begin
    if (reset) begin
      speed_sel <= SPEED_50MHZ;
      changed   <= 1'b0;
    end else begin
      speed_sel <= next_sel;
      changed   <= (next_sel != speed_sel);
    end
  end

endmodule

// File: tb/tb_speed_select_ctrl.sv
// Directed bench for speed_select_ctrl with short debounce/repeat timings,
// one wrapping and one saturating instance.
module tb_speed_select_ctrl;
  import speed_pkg::*;

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  logic   up_w = 1'b1, down_w = 1'b1;
  logic   up_s = 1'b1, down_s = 1'b1;
  speed_t sel_w, sel_s;
  logic   chg_w, chg_s;

  int checks = 0;
  int errors = 0;
  int pulses_w = 0;
  int pulses_s = 0;

  typedef struct {
    logic   up;
    logic   down;
    speed_t exp_w;
    speed_t exp_s;
    int     pul_w;
    int     pul_s;
  } vec_t;

  vec_t vecs[12];

  always #5 clock = ~clock;

  speed_select_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (10),
    .WRAP           (1'b1)
  ) dut_w (
    .clock     (clock),
    .reset     (reset),
    .key_up_n  (up_w),
    .key_down_n(down_w),
    .speed_sel (sel_w),
    .changed   (chg_w)
  );

  speed_select_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (10),
    .WRAP           (1'b0)
  ) dut_s (
    .clock     (clock),
    .reset     (reset),
    .key_up_n  (up_s),
    .key_down_n(down_s),
    .speed_sel (sel_s),
    .changed   (chg_s)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (chg_w === 1'b1) pulses_w++;
      if (chg_s === 1'b1) pulses_s++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    up_w   = 1'b1;
    down_w = 1'b1;
    up_s   = 1'b1;
    down_s = 1'b1;
    step(3);
    reset    = 1'b0;
    pulses_w = 0;
    pulses_s = 0;
  endtask

  initial begin
    int p0;

    vecs[0]  = '{1'b1, 1'b0, 2'b01, 2'b01, 1, 1};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 2'b10, 1, 1};
    vecs[2]  = '{1'b1, 1'b0, 2'b11, 2'b11, 1, 1};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 2'b11, 1, 0};
    vecs[4]  = '{1'b1, 1'b1, 2'b00, 2'b11, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 2'b10, 1, 1};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, 2'b01, 1, 1};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 2'b00, 1, 1};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 1, 0};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 2'b00, 1, 0};
    vecs[10] = '{1'b1, 1'b1, 2'b11, 2'b00, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 2'b01, 1, 1};

    // Reset state
    reset = 1'b1;
    step(3);
    check("reset_sel_w", sel_w, 0);
    check("reset_chg_w", chg_w, 0);
    check("reset_sel_s", sel_s, 0);
    reset    = 1'b0;
    pulses_w = 0;
    pulses_s = 0;

    // Single press, exact latency 2 + 4 + 1
    up_w = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      if (c == 6) begin
        check("lat_pre_sel", sel_w, 0);
        up_w = 1'b1;
      end
      if (c == 7) begin
        check("lat_sel", sel_w, 1);
        check("lat_chg", chg_w, 1);
      end
      if (c == 8) check("lat_chg_drop", chg_w, 0);
    end
    step(20);
    check("single_pulses", pulses_w, 1);
    check("single_sel", sel_w, 1);

    // Glitch shorter than the debounce window
    p0   = pulses_w;
    up_w = 1'b0;
    step(3);
    up_w = 1'b1;
    step(20);
    check("glitch_sel", sel_w, 1);
    check("glitch_pulses", pulses_w - p0, 0);

    // Auto-repeat while held
    do_reset();
    up_w = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      case (c)
        6:  check("rep_pre", sel_w, 0);
        7:  begin check("rep_7", sel_w, 1); check("rep_7_chg", chg_w, 1); end
        16: check("rep_16", sel_w, 1);
        17: begin check("rep_17", sel_w, 2); check("rep_17_chg", chg_w, 1); end
        27: begin check("rep_27", sel_w, 3); check("rep_27_chg", chg_w, 1); end
        37: begin check("rep_37", sel_w, 0); check("rep_37_chg", chg_w, 1); end
        default: ;
      endcase
    end
    check("rep_pulses", pulses_w, 4);
    up_w = 1'b1;
    step(20);

    // Simultaneous up and down from reset
    do_reset();
    up_w   = 1'b0;
    down_w = 1'b0;
    step(6);
    up_w   = 1'b1;
    down_w = 1'b1;
    step(20);
    check("both_sel", sel_w, 0);
    check("both_pulses", pulses_w, 0);

    // Table: press patterns on both the wrapping and saturating instances
    do_reset();
    for (int v = 0; v < 12; v++) begin
      int pw, ps;
      pw     = pulses_w;
      ps     = pulses_s;
      up_w   = ~vecs[v].up;
      up_s   = ~vecs[v].up;
      down_w = ~vecs[v].down;
      down_s = ~vecs[v].down;
      step(6);
      up_w   = 1'b1;
      up_s   = 1'b1;
      down_w = 1'b1;
      down_s = 1'b1;
      step(14);
      check($sformatf("vec%0d_sel_wrap", v), sel_w, vecs[v].exp_w);
      check($sformatf("vec%0d_sel_sat", v), sel_s, vecs[v].exp_s);
      check($sformatf("vec%0d_pulses_wrap", v), pulses_w - pw, vecs[v].pul_w);
      check($sformatf("vec%0d_pulses_sat", v), pulses_s - ps, vecs[v].pul_s);
    end

    // Down wraps to 11, then reset aborts a half-debounced press
    do_reset();
    down_w = 1'b0;
    step(6);
    down_w = 1'b1;
    step(14);
    check("abort_wrap_sel", sel_w, 3);
    down_w = 1'b0;
    step(4);
    reset  = 1'b1;
    down_w = 1'b1;
    step(2);
    reset = 1'b0;
    p0    = pulses_w;
    step(20);
    check("abort_sel", sel_w, 0);
    check("abort_pulses", pulses_w - p0, 0);

    // Key held across reset release is debounced afresh
    up_w  = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      if (c == 6) begin
        check("held_pre", sel_w, 0);
        up_w = 1'b1;
      end
      if (c == 7) begin
        check("held_sel", sel_w, 1);
        check("held_chg", chg_w, 1);
      end
    end
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
